uart_freq_cmd: RTL and testbench
================================

Name: uart_freq_cmd

Overview:
Serial command receiver that sits directly upstream of the square-wave channel generator. It accepts 8N1 UART frames from the host Python tool and decodes a framed, checksummed 32-bit half-period value. It drives the generator's FREQ_VAL input and pulses a strobe when a new value is accepted. On reset, or until the first valid command arrives, it presents DEFAULT_FREQ.

Parameters:
CLKS_PER_BIT, 868, clk_100MHz cycles per UART bit (100 MHz / 115200 baud); minimum legal value is 4.
DEFAULT_FREQ, 500, value driven on freq_val after reset.
MIN_FREQ, 1, smallest payload accepted; smaller payloads are rejected.
TIMEOUT_CLKS, 1000000, maximum idle cycles allowed between bytes inside a frame (10 ms).

Ports:
clk_100MHz  input  1  system clock
RSTN  input  1  reset, asynchronous, active-low
uart_rx  input  1  asynchronous serial input, idle high
freq_val  output  32  current accepted half-period count, feeds the generator
freq_update  output  1  one-cycle pulse in the cycle freq_val changes
cmd_err  output  1  one-cycle pulse on any rejected or aborted frame
busy  output  1  high while the parser is outside WAIT_SYNC

Behaviour:
- Reset is asynchronous, active-low, on clk_100MHz. Reset values:
  - freq_val = DEFAULT_FREQ; freq_update = 0; cmd_err = 0; busy = 0
  - synchroniser flops = 1; RX FSM = IDLE; parser = WAIT_SYNC; all counters = 0
- Input sync: uart_rx passes through a 2-flop synchroniser. All logic uses the synchronised signal rx_s.
- RX FSM:
  - IDLE: a falling rx_s moves to START and clears the bit counter.
  - START: waits CLKS_PER_BIT/2 cycles (integer division), then samples. If rx_s = 1, treat as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: samples every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register.
  - STOP: samples after CLKS_PER_BIT cycles.
    - rx_s = 1: byte_valid pulses for 1 cycle with the byte, then IDLE.
    - rx_s = 0: frame_err pulses, the byte is discarded, and the FSM waits in IDLE until rx_s = 1 before accepting a new start bit.
- Parser FSM, states WAIT_SYNC, B3, B2, B1, B0, CHK:
  - WAIT_SYNC: byte 0xA5 goes to B3; any other byte is ignored silently.
  - B3..B0: capture the payload big-endian (B3 = bits 31:24).
  - A 0xA5 inside the payload or checksum is treated as data, never as a resync.
  - CHK: the expected checksum is B3^B2^B1^B0.
    - On match and payload >= MIN_FREQ: freq_val takes the payload and freq_update pulses, both in the cycle after the checksum byte_valid. Return to WAIT_SYNC.
    - On mismatch or payload < MIN_FREQ: cmd_err pulses in that same cycle and freq_val holds. Return to WAIT_SYNC.
- Timeout:
  - An idle counter runs in states B3..CHK, clears on each byte_valid, and holds at 0 in WAIT_SYNC.
  - When it reaches TIMEOUT_CLKS: cmd_err pulses, the parser goes to WAIT_SYNC, and the partial payload is discarded.
- Framing error: frame_err in WAIT_SYNC is ignored. Outside WAIT_SYNC it causes cmd_err and a return to WAIT_SYNC.
- Simultaneous events: if a timeout and a byte_valid occur in the same cycle, byte_valid wins and the timeout is ignored. freq_update and cmd_err are never high in the same cycle.
- busy = (parser != WAIT_SYNC).
- freq_val changes only on freq_update; it is glitch-free and registered.
- Reset mid-frame discards all partial state; freq_val returns to DEFAULT_FREQ.
- Back-to-back frames with no idle gap between stop and start bits must be accepted.

Test Plan:
- Release reset with no traffic -> freq_val = 500, freq_update / cmd_err / busy stay 0 for 10000 cycles.
- CLKS_PER_BIT = 8; send A5 00 00 04 E2 E6 -> the cycle after the E6 byte_valid: freq_val = 1250 and freq_update = 1 for exactly 1 cycle; busy = 0 afterwards.
- Send A5 00 00 04 E2 E7 (bad checksum), then A5 00 00 00 00 00 (payload 0 < MIN_FREQ) -> two cmd_err pulses, freq_val stays 1250, freq_update never asserted.
- Send 55 12 A5 00 00 01 A5 A4 (leading junk, 0xA5 as payload data; checksum 00^00^01^A5 = A4) -> freq_val = 0x000001A5 = 421, one freq_update, no cmd_err.
- TIMEOUT_CLKS = 200; send A5 00 then stay idle -> cmd_err 200 cycles after the 00 byte_valid, busy drops. Then send a full valid frame for 1000 -> accepted.
- Send A5 00 with a stop bit forced to 0 on the second byte -> cmd_err, parser back in WAIT_SYNC. Assert RSTN low mid-byte of a later frame -> freq_val = 500 immediately, and the next valid frame is accepted normally.

Source files
------------

// File: rtl/uart_freq_cmd.sv
// -----------------------------------------------------------------------------
// uart_freq_cmd
//
// Serial command receiver feeding the square-wave channel generator.
// Receives 8N1 UART bytes and parses frames of the form
//     0xA5, B3, B2, B1, B0, CHK      (CHK = B3 ^ B2 ^ B1 ^ B0)
// where B3..B0 is a big-endian 32-bit half-period count. A frame with a
// matching checksum and a payload >= MIN_FREQ replaces freq_val. Any other
// completed, aborted or timed-out frame pulses cmd_err.
//
// Ports:
//   clk_100MHz   in   system clock
//   RSTN         in   asynchronous active-low reset
//   uart_rx      in   asynchronous serial input, idle high
//   freq_val     out  [31:0] accepted half-period count (DEFAULT_FREQ at reset)
//   freq_update  out  one-cycle pulse in the cycle freq_val takes a new value
//   cmd_err      out  one-cycle pulse on any rejected or aborted frame
//   busy         out  high while the parser is inside a frame
// -----------------------------------------------------------------------------
module uart_freq_cmd #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DEFAULT_FREQ = 500,
    parameter int unsigned MIN_FREQ     = 1,
    parameter int unsigned TIMEOUT_CLKS = 1000000
) (
    input  logic        clk_100MHz,
    input  logic        RSTN,
    input  logic        uart_rx,
    output logic [31:0] freq_val,
    output logic        freq_update,
    output logic        cmd_err,
    output logic        busy
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CLKS);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    // -------------------------------------------------------------------------
    // Input synchroniser
    // -------------------------------------------------------------------------
    logic sync1_q;
    logic rx_s_q;
    logic rx_prev_q;

    always_ff @(posedge clk_100MHz or negedge RSTN) begin
        if (!RSTN) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= uart_rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // -------------------------------------------------------------------------
    // UART receive FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q,  clk_cnt_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]       shift_q,    shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q,  frame_err_d;

    always_ff @(posedge clk_100MHz or negedge RSTN) begin
        if (!RSTN) begin
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                // Edge-triggered start detection: after a framing error the
                // line may still be low, and a new start bit is only accepted
                // once it has returned high.
                if (rx_prev_q && !rx_s_q) begin
                    rx_state_d = RX_START;
                    bit_cnt_d  = '0;
                end
            end

            RX_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_s_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            default: begin
                rx_state_d = RX_IDLE;
                clk_cnt_d  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Frame parser FSM
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        P_WAIT_SYNC,
        P_B3,
        P_B2,
        P_B1,
        P_B0,
        P_CHK
    } p_state_t;

    p_state_t        p_state_q, p_state_d;
    logic [31:0]     payload_q, payload_d;
    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [31:0]     freq_val_q, freq_val_d;
    logic            freq_update_q, freq_update_d;
    logic            cmd_err_q, cmd_err_d;

    logic [TO_W-1:0] idle_cnt_inc;
    logic            timeout_hit;
    logic [7:0]      chk_expect;

    always_ff @(posedge clk_100MHz or negedge RSTN) begin
        if (!RSTN) begin
            p_state_q     <= P_WAIT_SYNC;
            payload_q     <= '0;
            idle_cnt_q    <= '0;
            freq_val_q    <= 32'(DEFAULT_FREQ);
            freq_update_q <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            p_state_q     <= p_state_d;
            payload_q     <= payload_d;
            idle_cnt_q    <= idle_cnt_d;
            freq_val_q    <= freq_val_d;
            freq_update_q <= freq_update_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    always_comb begin
        p_state_d     = p_state_q;
        payload_d     = payload_q;
        freq_val_d    = freq_val_q;
        freq_update_d = 1'b0;
        cmd_err_d     = 1'b0;

        idle_cnt_inc = idle_cnt_q + 1'b1;
        chk_expect   = payload_q[31:24] ^ payload_q[23:16] ^ payload_q[15:8] ^ payload_q[7:0];

        // The stored count never exceeds TIMEOUT_CLKS-1; the timeout fires in
        // the cycle the count would reach TIMEOUT_CLKS. A byte in the same
        // cycle suppresses it.
        timeout_hit = (p_state_q != P_WAIT_SYNC) && !byte_valid_q &&
                      (idle_cnt_inc == TO_LIMIT);

        if (p_state_q == P_WAIT_SYNC || byte_valid_q) begin
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_inc;
        end

        if (byte_valid_q) begin
            case (p_state_q)
                P_WAIT_SYNC: begin
                    if (shift_q == SYNC_BYTE) begin
                        p_state_d = P_B3;
                    end
                end
                P_B3: begin
                    payload_d = {payload_q[23:0], shift_q};
                    p_state_d = P_B2;
                end
                P_B2: begin
                    payload_d = {payload_q[23:0], shift_q};
                    p_state_d = P_B1;
                end
                P_B1: begin
                    payload_d = {payload_q[23:0], shift_q};
                    p_state_d = P_B0;
                end
                P_B0: begin
                    payload_d = {payload_q[23:0], shift_q};
                    p_state_d = P_CHK;
                end
                P_CHK: begin
                    p_state_d = P_WAIT_SYNC;
                    payload_d = '0;
                    if (shift_q == chk_expect && payload_q >= 32'(MIN_FREQ)) begin
                        freq_val_d    = payload_q;
                        freq_update_d = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: begin
                    p_state_d = P_WAIT_SYNC;
                end
            endcase
        end else if ((frame_err_q && p_state_q != P_WAIT_SYNC) || timeout_hit) begin
            p_state_d  = P_WAIT_SYNC;
            payload_d  = '0;
            idle_cnt_d = '0;
            cmd_err_d  = 1'b1;
        end
    end

    assign freq_val    = freq_val_q;
    assign freq_update = freq_update_q;
    assign cmd_err     = cmd_err_q;
    assign busy        = (p_state_q != P_WAIT_SYNC);

endmodule

// File: tb/tb_uart_freq_cmd.sv
// -----------------------------------------------------------------------------
// tb_uart_freq_cmd
//
// Scoreboard bench for uart_freq_cmd. Stimulus tasks push the expected
// outcome of each frame (update with value, or error) into a queue; a monitor
// pops one entry per freq_update / cmd_err pulse and compares.
// -----------------------------------------------------------------------------
module tb_uart_freq_cmd;

    localparam int unsigned CPB = 8;
    localparam int unsigned TO  = 200;
    localparam int unsigned DEF = 500;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx;
    logic [31:0] fv;
    logic        fu;
    logic        ce;
    logic        bz;

    always #5 clk = ~clk;

    uart_freq_cmd #(
        .CLKS_PER_BIT(CPB),
        .DEFAULT_FREQ(DEF),
        .MIN_FREQ(1),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk_100MHz (clk),
        .RSTN       (rstn),
        .uart_rx    (rx),
        .freq_val   (fv),
        .freq_update(fu),
        .cmd_err    (ce),
        .busy       (bz)
    );

    typedef struct {
        bit          upd;
        logic [31:0] val;
    } ev_t;

    ev_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_freq = DEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [31:0] p);
        return p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
    endfunction

    // ---------------------------------------------------------------- monitor
    logic [31:0] prev_fv   = DEF;
    logic        prev_rstn = 1'b0;
    ev_t         mon_e;

    always @(negedge clk) begin
        if (rstn && prev_rstn) begin
            if (fu && ce) begin
                check("update_err_exclusive", 32'd1, 32'd0);
            end
            if (!fu) begin
                check("freq_val_hold", fv, prev_fv);
            end
            if (fu || ce) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: got update=%0b err=%0b expected no event", fu, ce);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind_is_update", {31'b0, fu}, {31'b0, mon_e.upd});
                    if (mon_e.upd) begin
                        check("freq_val_on_update", fv, mon_e.val);
                    end
                end
            end
        end
        prev_fv   = fv;
        prev_rstn = rstn;
    end

    // ---------------------------------------------------------------- stimulus
    task automatic gap(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        gap(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            gap(CPB);
        end
        rx = stop_bit;
        gap(CPB);
        rx = 1'b1;
    endtask

    // Sends a complete frame; the outcome is derived from the frame rules and
    // queued just before the checksum byte goes out.
    task automatic send_cmd(input logic [31:0] p, input logic [7:0] chk, input int unsigned max_gap);
        ev_t e;
        bit  ok;
        ok = (chk == xsum(p)) && (p >= 32'd1);
        send_byte(8'hA5, 1'b1);
        gap($urandom_range(0, max_gap));
        for (int i = 3; i >= 0; i--) begin
            send_byte(p[i*8 +: 8], 1'b1);
            gap($urandom_range(0, max_gap));
        end
        e.upd = ok;
        e.val = ok ? p : model_freq;
        exp_q.push_back(e);
        if (ok) model_freq = p;
        send_byte(chk, 1'b1);
    endtask

    task automatic push_err();
        ev_t e;
        e.upd = 1'b0;
        e.val = model_freq;
        exp_q.push_back(e);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        bit          bad;
        logic [31:0] p;
        logic [7:0]  c;
        logic [7:0]  j;

        rstn = 1'b0;
        rx   = 1'b1;
        gap(5);
        check("reset_freq_val", fv, DEF);
        check("reset_freq_update", {31'b0, fu}, 32'd0);
        check("reset_cmd_err", {31'b0, ce}, 32'd0);
        check("reset_busy", {31'b0, bz}, 32'd0);
        rstn = 1'b1;

        // Quiet line after reset
        bad = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (fu || ce || bz) bad = 1'b1;
        end
        check("idle_quiet_outputs", {31'b0, bad}, 32'd0);
        check("idle_freq_val", fv, DEF);

        // Valid frame for 1250, with a mid-frame busy check
        send_byte(8'hA5, 1'b1);
        gap(3);
        check("busy_inside_frame", {31'b0, bz}, 32'd1);
        begin
            ev_t e;
            e.upd = 1'b1;
            e.val = 32'd1250;
            send_byte(8'h00, 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte(8'h04, 1'b1);
            send_byte(8'hE2, 1'b1);
            exp_q.push_back(e);
            model_freq = 32'd1250;
            send_byte(8'hE6, 1'b1);
        end
        gap(4);
        check("busy_after_frame", {31'b0, bz}, 32'd0);

        // Bad checksum, then payload below MIN_FREQ
        send_cmd(32'h0000_04E2, 8'hE7, 0);
        gap(10);
        send_cmd(32'h0000_0000, 8'h00, 0);
        gap(10);
        check("freq_val_after_rejects", fv, 32'd1250);

        // Leading junk and 0xA5 as payload data
        send_byte(8'h55, 1'b1);
        send_byte(8'h12, 1'b1);
        send_cmd(32'h0000_01A5, 8'hA4, 0);
        gap(10);
        check("freq_val_a5_payload", fv, 32'd421);

        // Inter-byte timeout
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        push_err();
        n = 0;
        while (!ce && n < TO + 60) begin
            @(negedge clk);
            n++;
        end
        check("timeout_within_window", {31'b0, (n >= TO - 10) && (n <= TO + 10)}, 32'd1);
        @(negedge clk);
        check("busy_after_timeout", {31'b0, bz}, 32'd0);
        send_cmd(32'd1000, xsum(32'd1000), 0);
        gap(10);

        // Framing error on the second byte of a frame
        send_byte(8'hA5, 1'b1);
        push_err();
        send_byte(8'h00, 1'b0);
        gap(20);
        check("busy_after_frame_err", {31'b0, bz}, 32'd0);

        // Randomised frames, junk, glitches and gaps
        for (int k = 0; k < 30; k++) begin
            for (int m = 0; m < int'($urandom_range(0, 2)); m++) begin
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h5A;
                send_byte(j, 1'b1);
                gap($urandom_range(0, 20));
            end
            case ($urandom_range(0, 5))
                0:       p = 32'd0;
                1:       p = $urandom_range(1, 255);
                default: p = $urandom;
            endcase
            c = xsum(p);
            if ($urandom_range(0, 4) == 0) c = c ^ (8'd1 << $urandom_range(0, 7));
            send_cmd(p, c, 20);
            gap($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) begin
                rx = 1'b0;
                gap(2);
                rx = 1'b1;
                gap(12);
            end
        end

        // Known non-default value, then reset in the middle of a byte
        send_cmd(32'd12345, xsum(32'd12345), 5);
        gap(10);
        check("freq_val_before_reset", fv, 32'd12345);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        rx = 1'b0;
        gap(CPB * 3);
        #2;
        rstn = 1'b0;
        #1;
        check("freq_val_in_reset", fv, DEF);
        check("busy_in_reset", {31'b0, bz}, 32'd0);
        model_freq = DEF;
        rx = 1'b1;
        gap(5);
        rstn = 1'b1;
        gap(5);
        check("no_pending_after_reset", exp_q.size(), 32'd0);
        send_cmd(32'd777, xsum(32'd777), 3);

        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        gap(5);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("final_freq_val", fv, model_freq);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
